// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register block among NUM_REQ masters, one serialized
// transaction at a time. Optional grant-retain (lock) behaviour is built when GPIO_ARB_LOCK_EN is defined.
module gpio_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ-1:0]        lock,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      gpio_we,
  output logic                      gpio_re,
  output logic [DATA_W-1:0]         gpio_wdata,
  input  logic [DATA_W-1:0]         gpio_rdata,
  output logic [2:0]                dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SW    = IDX_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_ISS  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   win_next;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      sum_next;

  // Search upward from the pointer, wrapping modulo NUM_REQ; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr_q} + SW'(off);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      if (!found && req[sum[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sum_next = {1'b0, win} + SW'(1);
    if (sum_next == SW'(NUM_REQ)) sum_next = '0;
    win_next = sum_next[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = win;
          wdata_d = wdata[int'(win)*DATA_W +: DATA_W];
          ptr_d   = win_next;
          state_d = wr[win] ? S_WR : S_RD_ISS;
        end
      end
      S_WR:      state_d = S_ACK;
      S_RD_ISS:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rdata_d = gpio_rdata;
        state_d = S_ACK;
      end
      S_ACK: begin
        state_d = S_IDLE;
`ifdef GPIO_ARB_LOCK_EN
        // Rewinding the pointer to the holder gives it first claim at the next arbitration.
        if (lock[idx_q]) ptr_d = idx_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack        = '0;
    busy       = (state_q != S_IDLE);
    gpio_we    = (state_q == S_WR);
    gpio_re    = (state_q == S_RD_ISS);
    gpio_wdata = (state_q == S_WR) ? wdata_q : '0;
    if (state_q == S_ACK) ack[idx_q] = 1'b1;
  end

  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

`ifndef GPIO_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: transaction-latency model checked every cycle plus directed
// literal expectations. Build with GPIO_ARB_LOCK_EN defined to exercise grant retention.
module tb_gpio_bus_arbiter;
  localparam int N    = 2;
  localparam int W    = 32;
  localparam int MAXE = 4096;

  // Handshake: a master raises req (with wr/wdata) while the arbiter is idle; the arbiter
  // answers with a one-cycle ack pulse; the master drops req at the ack cycle.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req = '0;
  logic [N-1:0]   wr = '0;
  logic [N-1:0]   lock = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   ack;
  logic [W-1:0]   rdata;
  logic           busy;
  logic           gpio_we;
  logic           gpio_re;
  logic [W-1:0]   gpio_wdata;
  logic [W-1:0]   gpio_rdata = '0;
  logic [2:0]     dbg_state;
  logic [W-1:0]   gpio_reg = '0;

  int checks = 0;
  int errors = 0;

  gpio_bus_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .wdata(wdata), .lock(lock),
    .ack(ack), .rdata(rdata), .busy(busy), .gpio_we(gpio_we), .gpio_re(gpio_re),
    .gpio_wdata(gpio_wdata), .gpio_rdata(gpio_rdata), .dbg_state_o(dbg_state)
  );

  // GPIO block: register written on we, data_out registered on re and 0 otherwise.
  always @(posedge clk) begin
    if (gpio_we) gpio_reg <= gpio_wdata;
    gpio_rdata <= gpio_re ? gpio_reg : '0;
  end

  // ---------------- transaction model ----------------
  // Expected outputs indexed by the clock edge after which they are visible.
  bit         exp_we[MAXE];
  bit         exp_re[MAXE];
  bit         exp_busy[MAXE];
  bit [W-1:0] exp_wd[MAXE];
  bit [N-1:0] exp_ack[MAXE];
  int         edge_n = 0;
  int         m_ptr = 0;
  int         free_e = 0;
  int         cap_e = -1;
  int         lock_e = -1;
  int         lock_idx = 0;
  logic [W-1:0] m_rdata = '0;

  always @(posedge clk) begin
    int cur;
    int w;
    cur = edge_n;
    if (cur + 6 < MAXE) begin
      if (reset) begin
        m_ptr   = 0;
        m_rdata = '0;
        free_e  = cur + 1;
        cap_e   = -1;
        lock_e  = -1;
        for (int e = cur; e < cur + 6; e++) begin
          exp_we[e] = 0; exp_re[e] = 0; exp_busy[e] = 0; exp_wd[e] = '0; exp_ack[e] = '0;
        end
      end else begin
        if (cur == cap_e) m_rdata = gpio_rdata;
`ifdef GPIO_ARB_LOCK_EN
        if (cur == lock_e && lock[lock_idx]) m_ptr = lock_idx;
`endif
        if (cur >= free_e && req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          m_ptr    = (w + 1) % N;
          lock_idx = w;
          if (wr[w]) begin
            exp_we[cur]       = 1;
            exp_wd[cur]       = wdata[w*W +: W];
            exp_busy[cur]     = 1;
            exp_busy[cur + 1] = 1;
            exp_ack[cur + 1]  = N'(1) << w;
            free_e = cur + 3;
            lock_e = cur + 2;
          end else begin
            exp_re[cur]       = 1;
            exp_busy[cur]     = 1;
            exp_busy[cur + 1] = 1;
            exp_busy[cur + 2] = 1;
            exp_ack[cur + 2]  = N'(1) << w;
            cap_e  = cur + 2;
            free_e = cur + 4;
            lock_e = cur + 3;
          end
        end
      end
    end
    edge_n = cur + 1;
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (edge_n > 0 && edge_n < MAXE) begin
      e = edge_n - 1;
      check("gpio_we",    32'(gpio_we),  32'(exp_we[e]));
      check("gpio_re",    32'(gpio_re),  32'(exp_re[e]));
      check("gpio_wdata", gpio_wdata,    exp_wd[e]);
      check("busy",       32'(busy),     32'(exp_busy[e]));
      check("ack",        32'(ack),      32'(exp_ack[e]));
      check("rdata",      rdata,         m_rdata);
      check("we_re_excl", 32'(gpio_we & gpio_re), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  int grants[$];
  logic [W-1:0] exp_q[$];

  task automatic do_txn(input int idx, input bit wrv, input logic [W-1:0] d);
    bit got;
    got = 0;
    req[idx] = 1'b1;
    wr[idx]  = wrv;
    wdata[idx*W +: W] = d;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ack[idx]) begin got = 1; break; end
    end
    req[idx] = 1'b0;
    if (!got) check("txn_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic collect(input int n, input bit drop_lock);
    bit done;
    done = 0;
    grants.delete();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (drop_lock && grants.size() >= 1) lock = '0;
      if (ack != '0) begin
        grants.push_back(ack[1] ? 1 : 0);
        if (grants.size() == n) begin done = 1; break; end
      end
    end
    if (!done) check("grant_timeout", 32'(grants.size()), 32'(n));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!busy) begin idle = 1; break; end
    end
    if (!idle) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_grants(input string name);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < grants.size()) check(name, 32'(grants[i]), exp_q[i]);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write from master 0: we at t+1, ack at t+2.
    req[0] = 1'b1; wr[0] = 1'b1; wdata[31:0] = 32'hA5A5_0001;
    @(negedge clk);
    check("t1_we", 32'(gpio_we), 32'd1);
    check("t1_wdata", gpio_wdata, 32'hA5A5_0001);
    @(negedge clk);
    check("t1_ack", 32'(ack), 32'd1);
    req[0] = 1'b0;
    @(negedge clk);

    // Read from master 1: re at t+1, ack and rdata at t+3, idle at t+4.
    req[1] = 1'b1; wr[1] = 1'b0;
    @(negedge clk);
    check("t2_re", 32'(gpio_re), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("t2_ack", 32'(ack), 32'd2);
    check("t2_rdata", rdata, 32'hA5A5_0001);
    req[1] = 1'b0;
    @(negedge clk);
    check("t2_busy", 32'(busy), 32'd0);

    // Both masters writing continuously from reset alternate 0,1,0,1.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr = 2'b11; wdata = {32'h2, 32'h1}; req = 2'b11;
    collect(4, 1'b0);
    req = '0;
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    check_grants("t3_grant");
    wait_idle();

    // Read back last write, then reset during RD_WAIT drops the transaction.
    do_txn(1, 1'b0, '0);
    check("t4_pre_rdata", rdata, 32'h2);
    req[0] = 1'b1; wr[0] = 1'b0;
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_re", 32'(gpio_re), 32'd0);
    check("t4_rdata", rdata, 32'd0);
    check("t4_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t4_ack_after", 32'(ack), 32'd0);

    // Lock held by master 0 for its first transaction.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr = 2'b11; wdata = {32'h4, 32'h3}; lock = 2'b01; req = 2'b11;
    collect(3, 1'b1);
    req = '0;
    lock = '0;
`ifdef GPIO_ARB_LOCK_EN
    exp_q = '{32'd0, 32'd0, 32'd1};
`else
    exp_q = '{32'd0, 32'd1, 32'd0};
`endif
    check_grants("t5_grant");
    wait_idle();

    // rdata holds across a later write and idle cycles.
    do_txn(0, 1'b1, 32'h1234_5678);
    do_txn(1, 1'b0, '0);
    check("t6_read", rdata, 32'h1234_5678);
    do_txn(0, 1'b1, 32'hFFFF_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t6_hold", rdata, 32'h1234_5678);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
